pipe_frontend_ctrl: RTL and testbench
=====================================

Name: pipe_frontend_ctrl

Overview:
Consumer side of the hazard handshake. Takes pc_en/id_en/flushed from hazard_unit and the instruction/data memory handshake, and owns the IF/ID pipeline register. Produces the final PC write enable and the ID/EX enable/bubble controls. Keeps saturating stall/flush counters for the debug/perf path. Sits between the fetch stage and the decode stage of the datapath.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on flush or fetch bubble
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
ihit  in  1  instruction memory returned instr_in this cycle
dmem_req  in  1  MEM stage has an outstanding data read or write
dhit  in  1  data memory completes the request this cycle
instr_in  in  32  fetched instruction
npc_in  in  32  PC+4 of fetched instruction
pc_en  in  1  from hazard_unit: PC may advance
id_en  in  1  from hazard_unit: IF/ID may load; 0 = load-use stall
flushed  in  1  from hazard_unit: taken jump/jr/branch, squash IF/ID
halt_id  in  1  decode stage holds HALT opcode (qualified by valid_id)
instr_id  out  32  IF/ID instruction
npc_id  out  32  IF/ID PC+4
valid_id  out  1  IF/ID holds a real instruction
pc_we  out  1  PC register write enable
ex_en  out  1  ID/EX register load enable
ex_bubble  out  1  ID/EX loads zeroed controls this cycle
halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with a load-use stall
flush_cnt  out  CNT_W  flush events

Behaviour:
- Reset (RST=1 at edge): instr_id=NOP_INSTR, npc_id=0, valid_id=0, state=RUN, halted=0, both counters 0. Combinational outputs are 0 while RST=1.
- freeze = dmem_req & ~dhit.
- FSM states: RUN, FREEZE, HALTED. halted = (state==HALTED), registered.
- RUN->FREEZE when freeze=1. FREEZE->RUN when freeze=0. Re-evaluate the same cycle: the cycle freeze drops is a normal RUN cycle.
- RUN->HALTED when halt_id & valid_id & ~freeze & ~flushed. HALTED is left only by RST.
- Per-cycle priority in RUN or FREEZE: freeze > flushed > load-use (~id_en) > fetch miss (~ihit) > normal.
- Freeze:
  - pc_we=0, ex_en=0, ex_bubble=0.
  - IF/ID holds.
  - Counters hold.
- Flush:
  - pc_we=1. The PC loads the target selected by pc_src, regardless of pc_en.
  - IF/ID loads NOP_INSTR with valid_id=0 and npc_id=0.
  - ex_en=1, ex_bubble=0.
  - flush_cnt += 1.
- Load-use:
  - pc_we=0.
  - IF/ID holds.
  - ex_en=1, ex_bubble=1. Exactly one bubble per stall cycle.
  - stall_cnt += 1.
- Fetch miss:
  - pc_we=0.
  - IF/ID loads NOP_INSTR with valid_id=0.
  - ex_en=1, ex_bubble=0.
- Normal:
  - pc_we = pc_en.
  - IF/ID loads instr_in and npc_in with valid_id=1.
  - ex_en=1, ex_bubble=0.
- HALTED:
  - pc_we=0.
  - IF/ID loads NOP_INSTR with valid_id=0. This loads once, then holds.
  - ex_en = ~freeze, so in-flight instructions drain; ex_bubble=0.
  - Counters hold.
- Counters saturate at all-ones and do not wrap.
- Latency: IF/ID outputs are valid one cycle after the qualifying edge. pc_we, ex_en and ex_bubble are combinational in the same cycle.
- Simultaneous events:
  - flushed & ~id_en resolves as flush, counts only flush_cnt.
  - halt_id & flushed does not halt; the HALT is squashed.
  - RST mid-freeze or mid-halt returns to RUN next cycle with all outputs at reset values.

Test Plan:
- Reset then ihit=1, pc_en=id_en=1, instr_in=32'h2008_0005 -> next cycle instr_id=32'h2008_0005, valid_id=1, pc_we=1, stall_cnt=0.
- id_en=0 for 2 cycles with instr_id=A -> pc_we=0 and ex_bubble=1 both cycles, instr_id stays A, stall_cnt=2.
- flushed=1 with id_en=0 in the same cycle -> pc_we=1, next instr_id=NOP_INSTR with valid_id=0, flush_cnt=1, stall_cnt unchanged.
- dmem_req=1, dhit=0 for 3 cycles, then dhit=1 while flushed=1:
  - during the freeze: ex_en=0, pc_we=0, IF/ID held.
  - on the dhit cycle: flush applied, pc_we=1.
- HALT in ID with valid_id=1 -> halted=1 next cycle, pc_we=0 thereafter, valid_id=0; RST=1 -> halted=0, state RUN.
- Force stall_cnt to 16'hFFFE, stall 3 cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipe_frontend_ctrl.sv
// Front-end pipeline control: applies hazard-unit and memory-handshake decisions
// to the IF/ID register, PC write enable and ID/EX controls, and counts stalls and flushes.
module pipe_frontend_ctrl #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dmem_req,
   input  logic             dhit,
   input  logic [31:0]      instr_in,
   input  logic [31:0]      npc_in,
   input  logic             pc_en,
   input  logic             id_en,
   input  logic             flushed,
   input  logic             halt_id,
   output logic [31:0]      instr_id,
   output logic [31:0]      npc_id,
   output logic             valid_id,
   output logic             pc_we,
   output logic             ex_en,
   output logic             ex_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FREEZE,
      ST_HALTED
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      npc_q, npc_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             pc_we_c, ex_en_c, ex_bubble_c;
   logic             freeze;

   assign freeze = dmem_req & ~dhit;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      npc_d       = npc_q;
      valid_d     = valid_q;
      stall_d     = stall_q;
      flush_d     = flush_q;
      pc_we_c     = 1'b0;
      ex_en_c     = 1'b0;
      ex_bubble_c = 1'b0;

      if (state_q == ST_HALTED) begin
         // Let in-flight instructions drain while fetch is parked on a NOP.
         ex_en_c = ~freeze;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (freeze) begin
         state_d = ST_FREEZE;
      end else begin
         // The cycle a freeze releases behaves exactly like a RUN cycle.
         state_d = ST_RUN;
         ex_en_c = 1'b1;
         if (flushed) begin
            pc_we_c = 1'b1;
            instr_d = NOP_INSTR;
            npc_d   = '0;
            valid_d = 1'b0;
            if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
         end else if (!id_en) begin
            ex_bubble_c = 1'b1;
            if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
         end else if (!ihit) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end else begin
            pc_we_c = pc_en;
            instr_d = instr_in;
            npc_d   = npc_in;
            valid_d = 1'b1;
         end
         if (halt_id && valid_q && !flushed) state_d = ST_HALTED;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_RUN;
         instr_q <= NOP_INSTR;
         npc_q   <= '0;
         valid_q <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign instr_id  = instr_q;
   assign npc_id    = npc_q;
   assign valid_id  = valid_q;
   assign halted    = (state_q == ST_HALTED);
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
   assign pc_we     = pc_we_c & ~RST;
   assign ex_en     = ex_en_c & ~RST;
   assign ex_bubble = ex_bubble_c & ~RST;

endmodule

// File: tb/tb_pipe_frontend_ctrl.sv
// Directed-vector bench for pipe_frontend_ctrl with hand-computed expected values.
module tb_pipe_frontend_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dmem_req, dhit, pc_en, id_en, flushed, halt_id;
   logic [31:0] instr_in, npc_in;
   logic [31:0] instr_id, npc_id;
   logic        valid_id, pc_we, ex_en, ex_bubble, halted;
   logic [15:0] stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   pipe_frontend_ctrl #(.NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .instr_in(instr_in), .npc_in(npc_in), .pc_en(pc_en), .id_en(id_en),
      .flushed(flushed), .halt_id(halt_id), .instr_id(instr_id), .npc_id(npc_id),
      .valid_id(valid_id), .pc_we(pc_we), .ex_en(ex_en), .ex_bubble(ex_bubble),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle; inputs are changed and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic ih, input logic pe, input logic ie, input logic fl,
                        input logic [31:0] ins, input logic [31:0] npc);
      ihit = ih; pc_en = pe; id_en = ie; flushed = fl; instr_in = ins; npc_in = npc;
      #1;
   endtask

   task automatic ctl(input string tag, input logic we, input logic en, input logic bub);
      chk({tag, ".pc_we"}, {31'b0, pc_we}, {31'b0, we});
      chk({tag, ".ex_en"}, {31'b0, ex_en}, {31'b0, en});
      chk({tag, ".ex_bubble"}, {31'b0, ex_bubble}, {31'b0, bub});
   endtask

   task automatic ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc, input logic v);
      chk({tag, ".instr_id"}, instr_id, ins);
      chk({tag, ".npc_id"}, npc_id, npc);
      chk({tag, ".valid_id"}, {31'b0, valid_id}, {31'b0, v});
   endtask

   task automatic cnts(input string tag, input logic [15:0] st, input logic [15:0] fc);
      chk({tag, ".stall_cnt"}, {16'b0, stall_cnt}, {16'b0, st});
      chk({tag, ".flush_cnt"}, {16'b0, flush_cnt}, {16'b0, fc});
   endtask

   initial begin
      RST = 1'b1; dmem_req = 1'b0; dhit = 1'b0; halt_id = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); step();

      // Reset state; combinational outputs forced low while RST is high.
      ifid("rst", 32'h0, 32'h0, 1'b0);
      cnts("rst", 16'h0, 16'h0);
      chk("rst.halted", {31'b0, halted}, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h2008_0005, 32'h4);
      ctl("rst_gate", 1'b0, 1'b0, 1'b0);
      RST = 1'b0; #1;

      // Normal fetch.
      ctl("norm", 1'b1, 1'b1, 1'b0);
      step();
      ifid("norm", 32'h2008_0005, 32'h4, 1'b1);
      cnts("norm", 16'd0, 16'd0);

      // Two load-use stall cycles.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h8);
         ctl("lu", 1'b0, 1'b1, 1'b1);
         step();
         ifid("lu", 32'h2008_0005, 32'h4, 1'b1);
      end
      cnts("lu", 16'd2, 16'd0);

      // Flush together with load-use: flush wins.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h8);
      ctl("fl_lu", 1'b1, 1'b1, 1'b0);
      step();
      ifid("fl_lu", 32'h0, 32'h0, 1'b0);
      cnts("fl_lu", 16'd2, 16'd1);

      // Load a real instruction, then freeze 3 cycles with a pending load-use.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'hC);
      step();
      ifid("pre_frz", 32'h1111_1111, 32'hC, 1'b1);
      dmem_req = 1'b1; dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 32'h10);
         ctl("frz", 1'b0, 1'b0, 1'b0);
         step();
         ifid("frz", 32'h1111_1111, 32'hC, 1'b1);
      end
      cnts("frz", 16'd2, 16'd1);
      dhit = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 32'h10);
      ctl("dhit_fl", 1'b1, 1'b1, 1'b0);
      step();
      ifid("dhit_fl", 32'h0, 32'h0, 1'b0);
      cnts("dhit_fl", 16'd2, 16'd2);
      dmem_req = 1'b0; dhit = 1'b0;

      // Fetch miss holds npc; then pc_en=0 normal cycle.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h3333_3333, 32'h14);
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h9999_9999, 32'h18);
      ctl("miss", 1'b0, 1'b1, 1'b0);
      step();
      ifid("miss", 32'h0, 32'h14, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h5555_5555, 32'h18);
      ctl("pc_dis", 1'b0, 1'b1, 1'b0);
      step();
      ifid("pc_dis", 32'h5555_5555, 32'h18, 1'b1);

      // HALT squashed by a simultaneous flush.
      halt_id = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h6666_6666, 32'h1C);
      step();
      chk("halt_sq.halted", {31'b0, halted}, 32'h0);
      cnts("halt_sq", 16'd2, 16'd3);

      // Real HALT: valid instruction in ID with halt_id set.
      halt_id = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h6666_6666, 32'h1C);
      step();
      halt_id = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h7777_7777, 32'h20);
      ctl("halt_cyc", 1'b1, 1'b1, 1'b0);
      step();
      chk("halt.halted", {31'b0, halted}, 32'h1);
      ifid("halt", 32'h7777_7777, 32'h20, 1'b1);
      halt_id = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h8888_8888, 32'h24);
      ctl("halted", 1'b0, 1'b1, 1'b0);
      step();
      chk("halted2.halted", {31'b0, halted}, 32'h1);
      chk("halted2.instr_id", instr_id, 32'h0);
      chk("halted2.valid_id", {31'b0, valid_id}, 32'h0);
      cnts("halted2", 16'd2, 16'd3);
      dmem_req = 1'b1; #1;
      ctl("halt_frz", 1'b0, 1'b0, 1'b0);
      step();

      // Reset out of HALTED while a freeze is pending.
      RST = 1'b1; #1;
      ctl("rst_halt", 1'b0, 1'b0, 1'b0);
      step();
      RST = 1'b0; dmem_req = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hABCD_0001, 32'h28);
      chk("post_rst.halted", {31'b0, halted}, 32'h0);
      ifid("post_rst", 32'h0, 32'h0, 1'b0);
      cnts("post_rst", 16'd0, 16'd0);
      ctl("post_rst", 1'b1, 1'b1, 1'b0);
      step();
      ifid("post_rst_ld", 32'hABCD_0001, 32'h28, 1'b1);

      // Saturation: stall up to FFFE, then 3 more cycles must stop at FFFF.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 65534; i++) step();
      cnts("sat_pre", 16'hFFFE, 16'd0);
      for (int i = 0; i < 3; i++) begin
         ctl("sat", 1'b0, 1'b1, 1'b1);
         step();
      end
      cnts("sat", 16'hFFFF, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
